memory_bus_arbiter: RTL

MEMORY_BUS_ARBITER -- requirements
Module: memory_bus_arbiter

---
 rtl/memory_bus_arbiter.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/memory_bus_arbiter.sv
// memory_bus_arbiter: round-robin arbiter giving requesters A (CPU) and B (DMA) single-access ownership of one memory bus.
// Ports:
//   iCLK, iRST_n                    clock, asynchronous active-low reset
//   iReqX/iWeX/iBeX/iAddrX/iWDataX  requester X command (X = A, B)
//   oAckX, oRDataX, oGrantX         requester X completion pulse, read data, ownership
//   oReadEnable/oWriteEnable/oByteEnable/oAddress/oWriteData, iReadData  memory bus
//   oBusy                           high whenever a transaction is in flight
module memory_bus_arbiter #(
  parameter int READ_LATENCY = 1
) (
  input  logic        iCLK,
  input  logic        iRST_n,
  input  logic        iReqA,
  input  logic        iReqB,
  input  logic        iWeA,
  input  logic        iWeB,
  input  logic [3:0]  iBeA,
  input  logic [3:0]  iBeB,
  input  logic [31:0] iAddrA,
  input  logic [31:0] iAddrB,
  input  logic [31:0] iWDataA,
  input  logic [31:0] iWDataB,
  output logic        oAckA,
  output logic        oAckB,
  output logic [31:0] oRDataA,
  output logic [31:0] oRDataB,
  output logic        oGrantA,
  output logic        oGrantB,
  output logic        oReadEnable,
  output logic        oWriteEnable,
  output logic [3:0]  oByteEnable,
  output logic [31:0] oAddress,
  output logic [31:0] oWriteData,
  input  logic [31:0] iReadData,
  output logic        oBusy
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;
  state_t      r_state, w_state;
  logic [2:0]  r_cnt, w_cnt;
  logic        r_last_b, w_last_b;
  logic        r_we_l, w_we_l;
  logic        r_ack_a, w_ack_a, r_ack_b, w_ack_b;
  logic        r_grant_a, w_grant_a, r_grant_b, w_grant_b;
  logic        r_re, w_re, r_we, w_we, r_busy, w_busy;
  logic [3:0]  r_be, w_be;
  logic [31:0] r_addr, w_addr, r_wdata, w_wdata, r_rdata_a, w_rdata_a, r_rdata_b, w_rdata_b;
  logic        w_pick_b;
  // B wins only if A is idle or A was the last owner
  assign w_pick_b = iReqB & (~iReqA | ~r_last_b);
  always_comb begin
    w_state   = r_state;
    w_cnt     = r_cnt;
    w_last_b  = r_last_b;
    w_we_l    = r_we_l;
    w_ack_a   = 1'b0;
    w_ack_b   = 1'b0;
    w_grant_a = r_grant_a;
    w_grant_b = r_grant_b;
    w_re      = 1'b0;
    w_we      = 1'b0;
    w_be      = r_be;
    w_addr    = r_addr;
    w_wdata   = r_wdata;
    w_rdata_a = r_rdata_a;
    w_rdata_b = r_rdata_b;
    case (r_state)
      IDLE: if (iReqA | iReqB) begin
        w_grant_a = ~w_pick_b;
        w_grant_b = w_pick_b;
        w_last_b  = w_pick_b;
        w_we_l    = w_pick_b ? iWeB : iWeA;
        w_be      = w_pick_b ? iBeB : iBeA;
        w_addr    = w_pick_b ? iAddrB : iAddrA;
        w_wdata   = w_pick_b ? iWDataB : iWDataA;
        w_we      = w_we_l;
        w_re      = ~w_we_l;
        w_state   = ISSUE;
      end
      ISSUE: begin
        w_cnt   = 3'd0;
        w_re    = ~r_we_l;
        w_ack_a = r_we_l & r_grant_a;
        w_ack_b = r_we_l & r_grant_b;
        w_state = r_we_l ? DONE : WAIT;
      end
      WAIT: if (r_cnt == 3'(READ_LATENCY - 1)) begin
        w_rdata_a = r_grant_a ? iReadData : r_rdata_a;
        w_rdata_b = r_grant_b ? iReadData : r_rdata_b;
        w_ack_a   = r_grant_a;
        w_ack_b   = r_grant_b;
        w_state   = DONE;
      end else begin
        w_re  = 1'b1;
        w_cnt = r_cnt + 3'd1;
      end
      default: begin
        w_grant_a = 1'b0;
        w_grant_b = 1'b0;
        w_state   = IDLE;
      end
    endcase
    w_busy = w_state != IDLE;
  end
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_state   <= IDLE;
      r_cnt     <= 3'd0;
      r_last_b  <= 1'b1;
      r_we_l    <= 1'b0;
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_grant_a <= 1'b0;
      r_grant_b <= 1'b0;
      r_re      <= 1'b0;
      r_we      <= 1'b0;
      r_busy    <= 1'b0;
      r_be      <= 4'd0;
      r_addr    <= 32'd0;
      r_wdata   <= 32'd0;
      r_rdata_a <= 32'd0;
      r_rdata_b <= 32'd0;
    end else begin
      r_state   <= w_state;
      r_cnt     <= w_cnt;
      r_last_b  <= w_last_b;
      r_we_l    <= w_we_l;
      r_ack_a   <= w_ack_a;
      r_ack_b   <= w_ack_b;
      r_grant_a <= w_grant_a;
      r_grant_b <= w_grant_b;
      r_re      <= w_re;
      r_we      <= w_we;
      r_busy    <= w_busy;
      r_be      <= w_be;
      r_addr    <= w_addr;
      r_wdata   <= w_wdata;
      r_rdata_a <= w_rdata_a;
      r_rdata_b <= w_rdata_b;
    end
  end
  assign oAckA        = r_ack_a;
  assign oAckB        = r_ack_b;
  assign oGrantA      = r_grant_a;
  assign oGrantB      = r_grant_b;
  assign oReadEnable  = r_re;
  assign oWriteEnable = r_we;
  assign oByteEnable  = r_be;
  assign oAddress     = r_addr;
  assign oWriteData   = r_wdata;
  assign oRDataA      = r_rdata_a;
  assign oRDataB      = r_rdata_b;
  assign oBusy        = r_busy;
endmodule
